// File: rtl/adc_ctrl_pkg.sv
// Shared types and constants for the successive-approximation ADC controller.
// ADC_CTRL_PARITY_EN appends an even-parity bit to every serial frame.
package adc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        LOAD  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    localparam int ADC_WIDTH_DEFAULT = 8;

`ifdef ADC_CTRL_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Number of bits carried on the serial line per conversion.
    function automatic int frame_len(input int width);
        return width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/adc_ctrl_piso.sv
// Parallel-load shift register that streams one result frame MSB first.
// With ADC_CTRL_PARITY_EN the frame carries a trailing even-parity bit.
module adc_ctrl_piso
    import adc_ctrl_pkg::*;
#(
    parameter int WIDTH = ADC_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] data,
    output logic             dout,
    output logic             last
);

    localparam int FRAME = frame_len(WIDTH);
    localparam int CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;

    logic [FRAME-1:0] sr_reg;
    logic [FRAME-1:0] frame_word;
    logic [CNT_W-1:0] cnt_reg;

`ifdef ADC_CTRL_PARITY_EN
    assign frame_word = {data, ^data};
`else
    assign frame_word = data;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sr_reg  <= '0;
            cnt_reg <= '0;
        end else if (load) begin
            sr_reg  <= frame_word;
            cnt_reg <= CNT_W'(FRAME - 1);
        end else if (shift_en) begin
            sr_reg <= {sr_reg[FRAME-2:0], 1'b0};
            if (cnt_reg != '0)
                cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign dout = shift_en & sr_reg[FRAME-1];
    assign last = shift_en && (cnt_reg == '0);

endmodule

// File: rtl/adc_ctrl.sv
// Successive-approximation ADC controller: WIDTH trial cycles, a one-cycle
// result strobe, then a serial frame (plus parity with ADC_CTRL_PARITY_EN).
module adc_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int WIDTH = ADC_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             Start,
    input  logic             Compare,
    output logic [WIDTH-1:0] B,
    output logic             LoadReg,
    output logic             DataMark,
    output logic             SerialOutput
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             load_reg;
    logic             piso_last;
    logic             piso_dout;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg <= IDLE;
            b_reg     <= '0;
            idx_reg   <= '0;
            load_reg  <= 1'b0;
        end else begin
            load_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        state_reg <= CONV;
                        b_reg     <= {1'b1, {(WIDTH-1){1'b0}}};
                        idx_reg   <= IDX_W'(WIDTH - 1);
                    end
                end
                CONV: begin
                    // Resolve the current bit and tentatively set the next one.
                    b_reg[idx_reg] <= Compare;
                    if (idx_reg != '0) begin
                        b_reg[idx_reg - 1'b1] <= 1'b1;
                        idx_reg               <= idx_reg - 1'b1;
                    end else begin
                        state_reg <= LOAD;
                        load_reg  <= 1'b1;
                    end
                end
                LOAD: begin
                    state_reg <= SHIFT;
                end
                SHIFT: begin
                    if (piso_last)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    adc_ctrl_piso #(.WIDTH(WIDTH)) u_piso (
        .clk      (clk),
        .clr      (clr),
        .load     (state_reg == LOAD),
        .shift_en (state_reg == SHIFT),
        .data     (b_reg),
        .dout     (piso_dout),
        .last     (piso_last)
    );

    assign B            = b_reg;
    assign LoadReg      = load_reg;
    assign DataMark     = (state_reg == SHIFT);
    assign SerialOutput = piso_dout;

endmodule

// File: tb/tb_adc_ctrl.sv
// Randomized self-checking bench for adc_ctrl against a behavioural SAR model.
module tb_adc_ctrl;

    localparam int W = 8;
`ifdef ADC_CTRL_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif
    localparam int PERIOD = W + 1 + FL + 1;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         Start = 1'b0;
    logic         Compare;
    logic [W-1:0] B;
    logic         LoadReg;
    logic         DataMark;
    logic         SerialOutput;

    int           cmp_mode = 0;
    logic [W-1:0] thr = '0;
    logic         noise = 1'b1;
    logic         rnd = 1'b0;

    int checks = 0;
    int failures = 0;

    adc_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .clr          (clr),
        .Start        (Start),
        .Compare      (Compare),
        .B            (B),
        .LoadReg      (LoadReg),
        .DataMark     (DataMark),
        .SerialOutput (SerialOutput)
    );

    always #5 clk = ~clk;
    always @(negedge clk) rnd <= 1'($urandom);

    // Comparator: random garbage outside the conversion window.
    always_comb begin
        Compare = 1'b0;
        if (noise)              Compare = rnd;
        else if (cmp_mode == 1) Compare = 1'b1;
        else if (cmp_mode == 2) Compare = (thr >= B);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_cmp(input int mode, input logic [W-1:0] v, input logic [W-1:0] trial);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return v >= trial;
    endfunction

    task automatic run_conv(input int mode, input logic [W-1:0] v);
        logic [W-1:0] trials [W];
        logic [W-1:0] res;
        logic [W-1:0] mask;
        logic [FL-1:0] frame;
        res = '0;
        for (int k = W - 1; k >= 0; k--) begin
            mask = '0;
            mask[k] = 1'b1;
            trials[W-1-k] = res | mask;
            if (model_cmp(mode, v, res | mask)) res = res | mask;
        end
`ifdef ADC_CTRL_PARITY_EN
        frame = {res, ^res};
`else
        frame = res;
`endif
        @(negedge clk);
        cmp_mode = mode;
        thr = v;
        noise = 1'b0;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        for (int j = 0; j < W; j++) begin
            if (j > 0) @(negedge clk);
            check_val("conv_b", 32'(B), 32'(trials[j]));
            check_val("conv_loadreg", 32'(LoadReg), 0);
            check_val("conv_datamark", 32'(DataMark), 0);
        end
        @(negedge clk);
        noise = 1'b1;
        check_val("load_strobe", 32'(LoadReg), 1);
        check_val("load_b", 32'(B), 32'(res));
        check_val("load_datamark", 32'(DataMark), 0);
        for (int s = 0; s < FL; s++) begin
            @(negedge clk);
            check_val("shift_datamark", 32'(DataMark), 1);
            check_val("shift_bit", 32'(SerialOutput), 32'(frame[FL-1-s]));
            check_val("shift_loadreg", 32'(LoadReg), 0);
        end
        @(negedge clk);
        check_val("idle_datamark", 32'(DataMark), 0);
        check_val("idle_serial", 32'(SerialOutput), 0);
        check_val("idle_b_hold", 32'(B), 32'(res));
        $display("conv mode=%0d v=0x%02h result=0x%02h frame=%b", mode, v, res, frame);
    endtask

    initial begin
        int pulses;
        int n_last;
        #2;
        check_val("rst_b", 32'(B), 0);
        check_val("rst_loadreg", 32'(LoadReg), 0);
        check_val("rst_datamark", 32'(DataMark), 0);
        check_val("rst_serial", 32'(SerialOutput), 0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        $display("reset released");

        run_conv(1, '0);
        run_conv(0, '0);
        run_conv(2, 8'hA5);
        for (int r = 0; r < 12; r++) run_conv(2, W'($urandom_range(0, (1 << W) - 1)));
        run_conv(2, 8'h00);
        run_conv(2, 8'hFF);

        // Asynchronous clear during the fourth trial cycle.
        @(negedge clk);
        cmp_mode = 2;
        thr = W'($urandom);
        noise = 1'b0;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (3) @(negedge clk);
        #1 clr = 1'b0;
        #1;
        check_val("aclr_b", 32'(B), 0);
        check_val("aclr_loadreg", 32'(LoadReg), 0);
        check_val("aclr_datamark", 32'(DataMark), 0);
        check_val("aclr_serial", 32'(SerialOutput), 0);
        $display("async clear mid-conversion");
        @(negedge clk);
        clr = 1'b1;
        run_conv(2, W'($urandom));

        // Back-to-back frames with Start held, then dropped mid-frame.
        @(negedge clk);
        cmp_mode = 2;
        thr = W'($urandom);
        noise = 1'b0;
        Start = 1'b1;
        pulses = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (LoadReg) begin
                check_val("b2b_pulse_cycle", 32'(c), 32'(W + pulses * PERIOD));
                pulses++;
            end
        end
        check_val("b2b_pulse_count", 32'(pulses), 32'((59 - W) / PERIOD + 1));
        Start = 1'b0;
        n_last = 59 / PERIOD;
        pulses = 0;
        for (int c = 60; c < 110; c++) begin
            @(negedge clk);
            if (LoadReg) begin
                check_val("drop_pulse_cycle", 32'(c), 32'(n_last * PERIOD + W));
                pulses++;
            end
        end
        check_val("drop_pulse_count", 32'(pulses), 1);
        check_val("drop_idle_datamark", 32'(DataMark), 0);
        $display("back-to-back period=%0d checked", PERIOD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_ctrl.md
ADC_CTRL -- requirements
Module: adc_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the conversion resolution in bits (B width, trial count, serial frame length).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clr, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port Start, input, 1, conversion request; level-sensitive, sampled in IDLE.
REQ-005 SHALL have port Compare, input, 1, comparator result: 1 = analog input >= DAC word on B.
REQ-006 SHALL have port B, output, WIDTH, the DAC trial word during conversion, then the final result.
REQ-007 SHALL have port LoadReg, output, 1, a one-cycle strobe marking a valid final result on B.
REQ-008 SHALL have port DataMark, output, 1, high while SerialOutput carries frame bits.
REQ-009 SHALL have port SerialOutput, output, 1, the serial result, MSB first.

Function
REQ-010 SHALL implement a Moore FSM with states IDLE, CONV, LOAD, SHIFT; all outputs are registered or decoded from state and registers only.
REQ-011 In IDLE, a rising edge with Start=1 SHALL enter CONV with bit index i=WIDTH-1 and B = 1 followed by WIDTH-1 zeros (0x80 for WIDTH=8).
REQ-012 In IDLE with Start=0, the FSM SHALL hold, and B SHALL hold the last result.
REQ-013 At each rising edge in CONV, bit i of B SHALL take Compare.
REQ-014 At that same CONV edge, if i>0, bit i-1 SHALL be set to 1 and i SHALL decrement.
REQ-015 At that same CONV edge, if i=0, the FSM SHALL go to LOAD; CONV therefore lasts exactly WIDTH cycles.
REQ-016 LOAD SHALL last one cycle, with LoadReg=1 and B equal to the final result.
REQ-017 At the LOAD exit edge, the result SHALL be copied into the shift register, and the FSM SHALL enter SHIFT.
REQ-018 SHIFT SHALL last WIDTH cycles, with DataMark=1 and SerialOutput = result bits MSB first, one bit per cycle.
REQ-019 At the end of SHIFT, the FSM SHALL return to IDLE.
REQ-020 Outside SHIFT, DataMark and SerialOutput SHALL be 0; outside LOAD, LoadReg SHALL be 0.
REQ-021 Latency from the Start-sampling edge: LoadReg is high in the cycle after edge WIDTH (8), and the last serial bit ends at edge 2*WIDTH+1 (17).
REQ-022 With Start held high, conversions SHALL repeat back-to-back, one frame every 2*WIDTH+2 cycles (18), including one IDLE cycle.
REQ-023 Start falling mid-frame SHALL NOT abort the frame; the frame completes, then the FSM idles.
REQ-024 Compare SHALL be ignored outside CONV.

Reset
REQ-025 On clr=0, the state SHALL go asynchronously to IDLE, including mid-conversion or mid-shift.
REQ-026 On clr=0, B, the shift register and the bit index SHALL clear to 0.
REQ-027 On clr=0, LoadReg, DataMark and SerialOutput SHALL be 0.
REQ-028 After clr rises, the first Start sample SHALL occur at the next rising edge.

Configuration
REQ-029 With macro ADC_CTRL_PARITY_EN defined, SHIFT SHALL last WIDTH+1 cycles, and the extra last bit SHALL be even parity (XOR of the result).
REQ-030 With ADC_CTRL_PARITY_EN defined, DataMark SHALL stay high for all WIDTH+1 bits, and the frame period becomes 2*WIDTH+3.
REQ-031 Without ADC_CTRL_PARITY_EN, behaviour SHALL be exactly as in REQ-018 to REQ-022.

Structure
REQ-032 Package adc_ctrl_pkg SHALL hold the FSM state typedef (IDLE, CONV, LOAD, SHIFT) and the default width constant (8).
REQ-033 The serial stage SHALL be sub-module adc_ctrl_piso, a parallel-load shift register with a shift counter that produces the MSB-first stream and the last-bit flag.

Verification
REQ-034 Compare tied 1, Start pulse -> B trial sequence 0x80, 0xC0 ... 0xFF; LoadReg shows 0xFF; serial output 11111111 with DataMark high for 8 cycles.
REQ-035 Compare tied 0 -> B trial sequence 0x80, 0x40 ... 0x01; final B=0x00; serial output 00000000.
REQ-036 Behavioural comparator with Compare = (0xA5 >= B) -> final B=0xA5 on the LoadReg cycle; serial output 10100101.
REQ-037 clr driven low at the 4th CONV cycle -> all outputs 0 immediately; after release with Start=1, a fresh conversion starts from 0x80.
REQ-038 Start held high for 60 cycles -> LoadReg pulses exactly every 18 cycles; Start dropped mid-frame -> that frame completes, then no further LoadReg.
REQ-039 With ADC_CTRL_PARITY_EN and result 0xA5 -> 9 serial bits 101001010, DataMark high for 9 cycles.
